// File: rtl/mix_columns_seq.sv
// mix_columns_seq: AES ShiftRows then column-serial MixColumns (one shared column datapath, 4 cycles per state).
// Optional feature macro FINAL_ROUND_BYPASS_EN adds last_i, which skips MixColumns for the final AES round.
module mix_columns_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         valid_i,
   input  logic [127:0] state_i,
`ifdef FINAL_ROUND_BYPASS_EN
   input  logic         last_i,
`endif
   output logic         ready_o,
   output logic         valid_o,
   output logic [127:0] state_o,
   output logic         overflow_o
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t       state;
   logic [1:0]   col_cnt;
   logic [127:0] work, shifted, mixed_work;
   logic [31:0]  col, mixed_col;
   logic         accept, bypass;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign ready_o = state != BUSY;
   assign accept  = en & valid_i & ready_o;
`ifdef FINAL_ROUND_BYPASS_EN
   assign bypass  = last_i;
`else
   assign bypass  = 1'b0;
`endif

   // ShiftRows: row r of the output is row r of the input rotated left by r columns
   always_comb begin
      shifted = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shifted[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+r)%4)) -: 8];
   end

   // select the column addressed by col_cnt for the shared MixColumns datapath
   always_comb begin
      col = '0;
      for (int c = 0; c < 4; c++)
         col = (col_cnt == 2'(c)) ? work[127-32*c -: 32] : col;
   end

   // MixColumns on one column: rows of the circulant matrix {02,03,01,01}
   always_comb begin
      mixed_col[31:24] = xtime(col[31:24]) ^ xtime(col[23:16]) ^ col[23:16] ^ col[15:8] ^ col[7:0];
      mixed_col[23:16] = col[31:24] ^ xtime(col[23:16]) ^ xtime(col[15:8]) ^ col[15:8] ^ col[7:0];
      mixed_col[15:8]  = col[31:24] ^ col[23:16] ^ xtime(col[15:8]) ^ xtime(col[7:0]) ^ col[7:0];
      mixed_col[7:0]   = xtime(col[31:24]) ^ col[31:24] ^ col[23:16] ^ col[15:8] ^ xtime(col[7:0]);
   end

   // write the mixed column back into its slot of the work value
   always_comb begin
      mixed_work = work;
      for (int c = 0; c < 4; c++)
         mixed_work[127-32*c -: 32] = (col_cnt == 2'(c)) ? mixed_col : work[127-32*c -: 32];
   end

   // control FSM with registered result, pulse and sticky overflow; everything holds while en is low
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         col_cnt    <= 2'd0;
         work       <= '0;
         state_o    <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (en) begin
         valid_o <= 1'b0;
         if (valid_i && !ready_o)
            overflow_o <= 1'b1;
         if (accept) begin
            work    <= shifted;
            col_cnt <= 2'd0;
            state   <= bypass ? DONE : BUSY;
            if (bypass) begin
               state_o <= shifted;
               valid_o <= 1'b1;
            end
         end else if (state == BUSY) begin
            work    <= mixed_work;
            col_cnt <= col_cnt + 2'd1;
            if (col_cnt == 2'd3) begin
               state   <= DONE;
               state_o <= mixed_work;
               valid_o <= 1'b1;
            end
         end else
            state <= IDLE;
      end
endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 en  input  1  pipeline enable; when 0 every register (FSM, counter, data, outputs) holds.
REQ-004 valid_i  input  1  state_i carries a SubBytes result; driven by the sub_bytes stage valid_o.
REQ-005 state_i  input  128  post-SubBytes state; byte b = r+4c occupies bits [127-8b -: 8] (FIPS-197 order).
REQ-006 ready_o  output  1  block can accept a state this cycle.
REQ-007 valid_o  output  1  one-cycle pulse, state_o holds a new result.
REQ-008 state_o  output  128  MixColumns(ShiftRows(input)); same byte order as state_i.
REQ-009 overflow_o  output  1  sticky; set when valid_i arrives while ready_o=0.

Function
REQ-010 FSM states: IDLE, BUSY, DONE; 2-bit column counter col_cnt, 0..3.
REQ-011 Accept = en & valid_i & ready_o; on accept, ShiftRows(state_i) is loaded into a 128-bit work register, col_cnt<=0, FSM->BUSY.
REQ-012 ready_o = 1 in IDLE and DONE, 0 in BUSY (combinational from FSM state).
REQ-013 BUSY, each en edge: column col_cnt of work register replaced by its MixColumns result; col_cnt increments.
REQ-014 MixColumns per column: GF(2^8) multiply by {02},{03} via xtime, reduction polynomial 0x11B; one shared column datapath only.
REQ-015 On the edge processing col_cnt=3: FSM->DONE, state_o<=final work value, valid_o<=1.
REQ-016 Latency: accept at edge E -> valid_o high in the cycle after edge E+4 (en held 1); throughput one state per 5 cycles.
REQ-017 DONE: valid_o high exactly one en-cycle; next edge -> BUSY if accept else IDLE; valid_o<=0.
REQ-018 Back-to-back: accept in DONE is legal; new data loads, previous state_o unaffected until its own completion.
REQ-019 state_o holds last result until next completion; never changes outside REQ-015.
REQ-020 valid_i & en & !ready_o: input dropped, work register/FSM untouched, overflow_o<=1 (cleared only by reset).
REQ-021 en=0 during BUSY or DONE: FSM, col_cnt, valid_o frozen; valid_o pulse stretches while en=0 in DONE.

Reset
REQ-022 rst_n low: FSM=IDLE, col_cnt=0, work register=0, state_o=0, valid_o=0, overflow_o=0; ready_o thus 1.
REQ-023 Reset asserted mid-operation abandons the in-flight state; no valid_o after release.

Configuration
REQ-024 Macro FINAL_ROUND_BYPASS_EN: when defined, adds input last_i (1 bit, sampled with valid_i); accepted with last_i=1, FSM goes IDLE/DONE->DONE next edge, state_o=ShiftRows(state_i), valid_o=1 (latency 1, MixColumns skipped).
REQ-025 Without FINAL_ROUND_BYPASS_EN: no last_i port; every accepted state takes the full 4-column path.

Verification
REQ-026 FIPS-197 App.B rnd1: state_i=d42711aee0bf98f1b8b45de51e415230 -> valid_o after edge E+4, state_o=046681e5e0cb199a48f8d37a2806264c.
REQ-027 Column check: input whose ShiftRows gives column db135345 -> that column of state_o = 8e4da1bc; column f20a225c -> 9fdc589d.
REQ-028 Second valid_i during BUSY (cycle E+2) -> dropped, overflow_o=1 from E+3, first result unchanged; ready_o=0 at E+1..E+4.
REQ-029 en=0 for 3 cycles at E+2 -> valid_o delayed exactly 3 cycles, result identical to REQ-026.
REQ-030 rst_n pulsed low at E+2 -> all outputs 0 immediately, ready_o=1, no valid_o pulse afterwards.
REQ-031 FINAL_ROUND_BYPASS_EN defined, last_i=1, state_i=d42711aee0bf98f1b8b45de51e415230 -> valid_o after E+1, state_o=d4bf5d30e0b452aeb84111f11e2798e5.
